text_ram_write_arbiter: RTL and testbench
=========================================

// Module: text_ram_write_arbiter
// PURPOSE
//  Sole owner of the text RAM write port (clk_text_wr domain) that feeds the text pixel generator.
//  Shares the port between two requesters:
//  - the host (SPI command decoder): single-cell writes;
//  - an internal fill engine: clears or fills a run of cells with one character.
//  Round-robin arbitration under contention; registered write outputs.
// PARAMETERS
//  TEXT_WIDTH   60                       characters per text row
//  TEXT_HEIGHT  20                       text rows
//  TEXT_LEN     TEXT_WIDTH*TEXT_HEIGHT   cells in text RAM
//  TEXT_SZ      $clog2(TEXT_LEN)         address width
// PORTS
//  clk           in   1        write-side clock; same net as the text RAM clk_text_wr
//  reset_n       in   1        asynchronous, active-low reset
//  host_req      in   1        level; host has a write pending
//  host_addr     in   TEXT_SZ  cell address; stable while host_req=1
//  host_data     in   8        character; stable while host_req=1
//  host_ack      out  1        1-cycle pulse: host write consumed
//  host_err      out  1        1-cycle pulse with host_ack when host_addr >= TEXT_LEN
//  fill_start    in   1        1-cycle pulse: begin fill
//  fill_addr     in   TEXT_SZ  first cell of fill
//  fill_count    in   TEXT_SZ+1  cells to write (0..TEXT_LEN)
//  fill_char     in   8        character written to each cell
//  fill_busy     out  1        fill engine active
//  fill_done     out  1        1-cycle pulse: fill finished
//  text_wr_ena   out  1        to text RAM
//  text_wr_addr  out  TEXT_SZ  to text RAM
//  text_wr_data  out  8        to text RAM
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; last_grant=FILL, so the host wins the first contention.
//  Write port: at most one write per cycle. text_wr_* registered, valid the cycle after the grant decision.
//  Host: when granted, host_ack pulses in the same cycle text_wr_ena is driven.
//  - Requester drops or changes host_req/addr/data only after seeing ack.
//  - host_req held high after ack = new request, eligible next cycle.
//  - host_addr >= TEXT_LEN: ack and host_err pulse, no write (text_wr_ena stays 0).
//  FSM IDLE -> FILL on fill_start:
//  - latch fill_addr, fill_char and remaining=fill_count.
//  - fill_addr >= TEXT_LEN is clamped to 0.
//  FSM IDLE, fill_start with fill_count=0: fill_done pulses next cycle, no writes, fill_busy stays 0.
//  FSM FILL: each granted cycle writes cur_addr, then:
//  - cur_addr <- (cur_addr==TEXT_LEN-1) ? 0 : cur_addr+1 (wrap);
//  - remaining <- remaining-1.
//  FSM FILL -> IDLE: on the grant that makes remaining==0; fill_done pulses with that write on text_wr_ena.
//  FSM FILL, fill_busy: 1 from the cycle after fill_start through the cycle of the last write.
//  fill_start while busy: ignored, with no effect on the current fill.
//  Arbitration, only one requester eligible: that requester is granted.
//  Arbitration, both eligible: grant != last_grant, so they alternate. Fill gets >= 50% of cycles.
//  last_grant updates only on an actual grant.
//  fill_count > TEXT_LEN: saturate to TEXT_LEN.
//  Reset mid-fill: abort immediately, no fill_done, text_wr_ena=0.
// STRUCTURE
//  text_pkg: TEXT_WIDTH/HEIGHT/LEN/SZ constants; typedef enum logic {IDLE, FILL} fill_state_t.
//  Sub-module rr_arbiter_2: 2-requester round-robin arbiter.
//  - ports: clk, reset_n, req[1:0], gnt[1:0] (one-hot/zero), last-grant register inside.
//  Top level: fill FSM/counters, host checks, output registers.
// TESTING
//  1 Host write addr=5 data=8'h41, no fill -> next cycle wr_ena=1 addr=5 data=41 with host_ack; exactly one write.
//  2 Host addr=1200 (=TEXT_LEN) -> host_ack+host_err same cycle, wr_ena stays 0.
//  3 fill_start addr=1195 count=10 char=8'h20 -> writes addr 1195..1199, 0..4.
//    - fill_busy high for 10 cycles; fill_done with the write to addr 4.
//  4 Fill count=1200 plus host_req held high throughout -> grants alternate host/fill, host first.
//    - fill completes in 2400 cycles; every host ack matches one host write.
//  5 fill_start count=0 -> fill_done next cycle, no wr_ena. fill_start while busy -> no change to the sequence.
//  6 reset_n low mid-fill (after 3 writes), then high -> all outputs 0, no fill_done.
//    - a new fill_start afterwards runs normally.

Source files
------------

// File: rtl/text_pkg.sv
// Shared geometry and types for the text RAM write path.
// Constants are pre-sized so address/count comparisons stay width-matched.
package text_pkg;

  localparam int TEXT_WIDTH  = 60;
  localparam int TEXT_HEIGHT = 20;
  localparam int TEXT_LEN    = TEXT_WIDTH * TEXT_HEIGHT;
  localparam int TEXT_SZ     = $clog2(TEXT_LEN);

  localparam logic [TEXT_SZ-1:0] TEXT_LEN_ADDR  = TEXT_SZ'(TEXT_LEN);
  localparam logic [TEXT_SZ-1:0] TEXT_LAST_ADDR = TEXT_SZ'(TEXT_LEN - 1);
  localparam logic [TEXT_SZ:0]   TEXT_LEN_CNT   = (TEXT_SZ + 1)'(TEXT_LEN);

  typedef enum logic {IDLE, FILL} fill_state_t;

  // Cell after a, wrapping from the last cell back to cell 0.
  function automatic logic [TEXT_SZ-1:0] text_next_addr(input logic [TEXT_SZ-1:0] a);
    return (a == TEXT_LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter; under contention the requester that did not
// win last time is granted. Grant is combinational, history is registered.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    // History only moves on a real grant.
    if (gnt[0]) begin
      last_d = 1'b0;
    end else if (gnt[1]) begin
      last_d = 1'b1;
    end
  end

  // Requester 1 is treated as last winner so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/text_ram_write_arbiter.sv
// Owns the text RAM write port, sharing it between single host writes and a
// run-length fill engine; all write-port and handshake outputs are registered.
module text_ram_write_arbiter
  import text_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               host_req,
  input  logic [TEXT_SZ-1:0] host_addr,
  input  logic [7:0]         host_data,
  output logic               host_ack,
  output logic               host_err,
  input  logic               fill_start,
  input  logic [TEXT_SZ-1:0] fill_addr,
  input  logic [TEXT_SZ:0]   fill_count,
  input  logic [7:0]         fill_char,
  output logic               fill_busy,
  output logic               fill_done,
  output logic               text_wr_ena,
  output logic [TEXT_SZ-1:0] text_wr_addr,
  output logic [7:0]         text_wr_data
);

  fill_state_t        state_q, state_d;
  logic [TEXT_SZ-1:0] cur_addr_q, cur_addr_d;
  logic [TEXT_SZ:0]   remaining_q, remaining_d;
  logic [7:0]         char_q, char_d;

  logic               wr_ena_q, wr_ena_d;
  logic [TEXT_SZ-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               host_ack_q, host_ack_d;
  logic               host_err_q, host_err_d;
  logic               fill_done_q, fill_done_d;
  logic               fill_busy_q, fill_busy_d;

  logic               start_ok;
  logic [TEXT_SZ-1:0] start_addr;
  logic [TEXT_SZ:0]   start_cnt;
  logic               fill_active;
  logic [TEXT_SZ-1:0] eff_addr;
  logic [TEXT_SZ:0]   eff_rem;
  logic [TEXT_SZ:0]   rem_dec;
  logic [7:0]         eff_char;
  logic               host_elig;
  logic [1:0]         req;
  logic [1:0]         gnt;

  // A fill start competes for the port in the very cycle it arrives, using the
  // raw (clamped/saturated) inputs; afterwards the latched counters take over.
  assign start_ok    = (state_q == IDLE) && fill_start;
  assign start_addr  = (fill_addr >= TEXT_LEN_ADDR) ? '0 : fill_addr;
  assign start_cnt   = (fill_count > TEXT_LEN_CNT) ? TEXT_LEN_CNT : fill_count;
  assign fill_active = (state_q == FILL) || (start_ok && (start_cnt != '0));
  assign eff_addr    = (state_q == FILL) ? cur_addr_q  : start_addr;
  assign eff_rem     = (state_q == FILL) ? remaining_q : start_cnt;
  assign eff_char    = (state_q == FILL) ? char_q      : fill_char;
  assign rem_dec     = eff_rem - 1'b1;

  // While ack is showing, host_req still belongs to the request just served.
  assign host_elig   = host_req && !host_ack_q;
  assign req         = {fill_active, host_elig};

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt)
  );

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    char_d      = char_q;
    wr_ena_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    host_ack_d  = 1'b0;
    host_err_d  = 1'b0;
    fill_done_d = 1'b0;
    fill_busy_d = 1'b0;

    if (start_ok) begin
      char_d = fill_char;
      if (start_cnt == '0) begin
        fill_done_d = 1'b1;
      end
    end

    if (fill_active) begin
      state_d     = FILL;
      cur_addr_d  = eff_addr;
      remaining_d = eff_rem;
      fill_busy_d = 1'b1;
    end

    if (gnt[0]) begin
      host_ack_d = 1'b1;
      if (host_addr >= TEXT_LEN_ADDR) begin
        host_err_d = 1'b1;
      end else begin
        wr_ena_d  = 1'b1;
        wr_addr_d = host_addr;
        wr_data_d = host_data;
      end
    end else if (gnt[1]) begin
      wr_ena_d    = 1'b1;
      wr_addr_d   = eff_addr;
      wr_data_d   = eff_char;
      cur_addr_d  = text_next_addr(eff_addr);
      remaining_d = rem_dec;
      if (rem_dec == '0) begin
        state_d     = IDLE;
        fill_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      char_q      <= '0;
      wr_ena_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      host_ack_q  <= 1'b0;
      host_err_q  <= 1'b0;
      fill_done_q <= 1'b0;
      fill_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      char_q      <= char_d;
      wr_ena_q    <= wr_ena_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      host_ack_q  <= host_ack_d;
      host_err_q  <= host_err_d;
      fill_done_q <= fill_done_d;
      fill_busy_q <= fill_busy_d;
    end
  end

  assign host_ack     = host_ack_q;
  assign host_err     = host_err_q;
  assign fill_busy    = fill_busy_q;
  assign fill_done    = fill_done_q;
  assign text_wr_ena  = wr_ena_q;
  assign text_wr_addr = wr_addr_q;
  assign text_wr_data = wr_data_q;

endmodule

// File: tb/tb_text_ram_write_arbiter.sv
// Directed bench for text_ram_write_arbiter: host writes, fills, contention,
// zero-length and ignored fills, reset abort and clamp/saturate boundaries.
module tb_text_ram_write_arbiter;
  import text_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               host_req = 1'b0;
  logic [TEXT_SZ-1:0] host_addr = '0;
  logic [7:0]         host_data = '0;
  logic               host_ack;
  logic               host_err;
  logic               fill_start = 1'b0;
  logic [TEXT_SZ-1:0] fill_addr = '0;
  logic [TEXT_SZ:0]   fill_count = '0;
  logic [7:0]         fill_char = '0;
  logic               fill_busy;
  logic               fill_done;
  logic               text_wr_ena;
  logic [TEXT_SZ-1:0] text_wr_addr;
  logic [7:0]         text_wr_data;

  int checks = 0;
  int errors = 0;

  text_ram_write_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .host_req     (host_req),
    .host_addr    (host_addr),
    .host_data    (host_data),
    .host_ack     (host_ack),
    .host_err     (host_err),
    .fill_start   (fill_start),
    .fill_addr    (fill_addr),
    .fill_count   (fill_count),
    .fill_char    (fill_char),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .text_wr_ena  (text_wr_ena),
    .text_wr_addr (text_wr_addr),
    .text_wr_data (text_wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view {ena,ack,err,busy,done,data,addr}; bus fields masked when not of interest.
  function automatic logic [31:0] obs(input logic show_bus);
    logic [31:0] v;
    v = {8'h00, text_wr_ena, host_ack, host_err, fill_busy, fill_done, text_wr_data, text_wr_addr};
    if (!show_bus) v[TEXT_SZ+7:0] = '0;
    return v;
  endfunction

  function automatic logic [31:0] mk(input logic e, input logic a, input logic r, input logic b,
                                     input logic d, input logic [7:0] dt, input logic [TEXT_SZ-1:0] ad);
    return {8'h00, e, a, r, b, d, dt, ad};
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TEXT_SZ-1:0] ea;
    int nwr;
    logic done_seen;

    repeat (2) tick();
    check("reset", obs(1'b1), 32'h0);
    reset_n = 1'b1;
    tick();
    check("idle", obs(1'b1), 32'h0);

    // 1: single host write
    host_req = 1'b1; host_addr = 11'd5; host_data = 8'h41;
    tick();
    check("t1 write", obs(1'b1), mk(1, 1, 0, 0, 0, 8'h41, 11'd5));
    $display("t1 host write addr=%0d data=%h ack=%b", text_wr_addr, text_wr_data, host_ack);
    host_req = 1'b0;
    tick();
    check("t1 single", obs(1'b0), 32'h0);

    // 2: out-of-range host address
    host_req = 1'b1; host_addr = 11'd1200; host_data = 8'h55;
    tick();
    check("t2 err", obs(1'b0), mk(0, 1, 1, 0, 0, 8'h00, '0));
    $display("t2 host addr=1200 ack=%b err=%b ena=%b", host_ack, host_err, text_wr_ena);
    host_req = 1'b0;
    tick();
    check("t2 quiet", obs(1'b0), 32'h0);

    // 3: wrapping fill
    fill_start = 1'b1; fill_addr = 11'd1195; fill_count = 12'd10; fill_char = 8'h20;
    tick();
    fill_start = 1'b0;
    ea = 11'd1195;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3 w%0d", i), obs(1'b1), mk(1, 0, 0, 1, (i == 9), 8'h20, ea));
      $display("t3 fill write addr=%0d data=%h busy=%b done=%b", text_wr_addr, text_wr_data, fill_busy, fill_done);
      ea = (ea == 11'd1199) ? 11'd0 : ea + 11'd1;
      tick();
    end
    check("t3 end", obs(1'b0), 32'h0);

    // 4: full-screen fill against a host holding its request
    host_req = 1'b1; host_addr = 11'd7; host_data = 8'h48;
    fill_start = 1'b1; fill_addr = 11'd0; fill_count = 12'd1200; fill_char = 8'h2E;
    tick();
    fill_start = 1'b0;
    ea = '0;
    for (int k = 0; k <= 2400; k++) begin
      if (k % 2 == 0) begin
        check($sformatf("t4 c%0d", k), obs(1'b1), mk(1, 1, 0, (k < 2400), 0, 8'h48, 11'd7));
      end else begin
        check($sformatf("t4 c%0d", k), obs(1'b1), mk(1, 0, 0, 1, (k == 2399), 8'h2E, ea));
        ea = ea + 11'd1;
      end
      if (k == 2400) host_req = 1'b0;
      tick();
    end
    $display("t4 contention run of 2401 writes complete");
    check("t4 end", obs(1'b0), 32'h0);

    // 5: zero-length fill, then a fill_start while busy
    fill_start = 1'b1; fill_addr = 11'd3; fill_count = 12'd0; fill_char = 8'h77;
    tick();
    fill_start = 1'b0;
    check("t5 zero", obs(1'b0), mk(0, 0, 0, 0, 1, 8'h00, '0));
    $display("t5 zero-count fill done=%b ena=%b busy=%b", fill_done, text_wr_ena, fill_busy);
    tick();
    check("t5 zero after", obs(1'b0), 32'h0);
    fill_start = 1'b1; fill_addr = 11'd10; fill_count = 12'd4; fill_char = 8'h31;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5 w%0d", i), obs(1'b1), mk(1, 0, 0, 1, (i == 3), 8'h31, 11'(10 + i)));
      $display("t5 fill write addr=%0d data=%h done=%b", text_wr_addr, text_wr_data, fill_done);
      if (i == 1) begin
        fill_start = 1'b1; fill_addr = 11'd500; fill_count = 12'd2; fill_char = 8'h99;
      end else begin
        fill_start = 1'b0;
      end
      tick();
    end
    check("t5 end", obs(1'b0), 32'h0);

    // 6: reset in the middle of a fill
    fill_start = 1'b1; fill_addr = 11'd100; fill_count = 12'd10; fill_char = 8'h55;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6 w%0d", i), obs(1'b1), mk(1, 0, 0, 1, 0, 8'h55, 11'(100 + i)));
      if (i < 2) tick();
    end
    reset_n = 1'b0;
    #1;
    check("t6 async", obs(1'b1), 32'h0);
    tick();
    check("t6 held", obs(1'b1), 32'h0);
    reset_n = 1'b1;
    tick();
    check("t6 release", obs(1'b1), 32'h0);
    tick();
    check("t6 no done", obs(1'b1), 32'h0);
    $display("t6 reset abort: outputs cleared, no fill_done");
    fill_start = 1'b1; fill_addr = 11'd200; fill_count = 12'd2; fill_char = 8'h66;
    tick();
    fill_start = 1'b0;
    check("t6 new w0", obs(1'b1), mk(1, 0, 0, 1, 0, 8'h66, 11'd200));
    tick();
    check("t6 new w1", obs(1'b1), mk(1, 0, 0, 1, 1, 8'h66, 11'd201));
    tick();
    check("t6 new end", obs(1'b0), 32'h0);

    // 7: start address clamp and count saturation
    fill_start = 1'b1; fill_addr = 11'd1500; fill_count = 12'd2000; fill_char = 8'h2D;
    tick();
    fill_start = 1'b0;
    nwr = 0;
    done_seen = 1'b0;
    for (int k = 0; k < 1300; k++) begin
      if (k == 0) check("t7 clamp", obs(1'b1), mk(1, 0, 0, 1, 0, 8'h2D, 11'd0));
      if (text_wr_ena) nwr++;
      if (fill_done) begin
        done_seen = 1'b1;
        check("t7 last addr", 32'(text_wr_addr), 32'd1199);
        break;
      end
      tick();
    end
    check("t7 writes", nwr, 32'd1200);
    check("t7 done", 32'(done_seen), 32'd1);
    $display("t7 saturated fill wrote %0d cells", nwr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
